enc_pwm_mixer: RTL and testbench

Parametrised successor to the fixed 3-channel HSV mixer. CHANNELS quadrature rotary encoders each drive a WIDTH-bit level register, and each level sets the duty cycle of its own PWM output. Unlike the fixed mixer, it adds a Wishbone slave for reading and writing levels and control, selectable wrap or saturate counting, global enable, and output inversion. It sits inside the user project, between the GPIO pads and the management SoC bus.

---
 rtl/enc_pwm_mixer.sv | 157 +++++++++++++++
 tb/tb_enc_pwm_mixer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: per-channel quadrature encoder (x1 decode) driving a level
// register, with one PWM output per channel and a Wishbone register slave.
//   clk, reset_n         : clock, synchronous active-low reset
//   enc_a, enc_b         : asynchronous encoder phases, one bit per channel
//   pwm_out              : registered PWM output per channel
//   wbs_*                : Wishbone slave (CTRL at word 0, LEVEL[i] at word i+1)
module enc_pwm_mixer #(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    output logic [CHANNELS-1:0] pwm_out,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o
);

    localparam int unsigned IDX_W = 6;
    localparam logic [WIDTH-1:0] LVL_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync_b;
    logic [CHANNELS-1:0]                  r_hist_a;
    logic [CHANNELS-1:0]                  w_a_cur;
    logic [CHANNELS-1:0]                  w_b_cur;

    logic                                 r_enable;
    logic                                 r_wrap;
    logic                                 r_invert;
    logic [WIDTH-1:0]                     r_pwm_cnt;
    logic [CHANNELS-1:0][WIDTH-1:0]       w_level;
    logic [CHANNELS-1:0]                  w_raw;

    logic                                 w_req;
    logic                                 w_wr;
    logic [IDX_W-1:0]                     w_idx;
    logic [31:0]                          w_bmask;
    logic [WIDTH-1:0]                     w_mask;
    logic [31:0]                          w_rdata;
    logic                                 w_unused;

    assign w_a_cur = r_sync_a[SYNC_STAGES-1];
    assign w_b_cur = r_sync_b[SYNC_STAGES-1];

    assign w_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign w_wr    = w_req & wbs_we_i;
    assign w_idx   = wbs_adr_i[7:2];
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_mask  = w_bmask[WIDTH-1:0];

    assign w_unused = ^{wbs_adr_i[31:8], wbs_adr_i[1:0],
                        wbs_dat_i[31:WIDTH], w_bmask[31:WIDTH]};

    // Encoder input synchronisers plus one history flop on A for edge detect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_hist_a <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], enc_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], enc_b};
            r_hist_a <= w_a_cur;
        end
    end

    // Per-channel level register: bus write wins over a same-edge encoder step
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic             w_step;
        logic             w_hit;
        logic [WIDTH-1:0] w_nxt;
        logic [WIDTH-1:0] r_level;

        assign w_step = w_a_cur[g] & ~r_hist_a[g];
        assign w_hit  = w_wr & (w_idx == IDX_W'(g + 1));

        always_comb begin
            w_nxt = r_level;
            if (w_hit) begin
                w_nxt = (r_level & ~w_mask) | (wbs_dat_i[WIDTH-1:0] & w_mask);
            end else if (w_step) begin
                if (w_b_cur[g]) begin
                    if (r_level == '0) w_nxt = r_wrap ? LVL_MAX : '0;
                    else               w_nxt = r_level - WIDTH'(1);
                end else begin
                    if (r_level == LVL_MAX) w_nxt = r_wrap ? '0 : LVL_MAX;
                    else                    w_nxt = r_level + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) r_level <= '0;
            else          r_level <= w_nxt;
        end

        assign w_level[g] = r_level;
        assign w_raw[g]   = r_enable & (r_pwm_cnt < r_level);
    end

    // Control register; only byte lane 0 carries defined bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_enable <= 1'b1;
            r_wrap   <= 1'b0;
            r_invert <= 1'b0;
        end else if (w_wr && (w_idx == '0) && wbs_sel_i[0]) begin
            r_enable <= wbs_dat_i[0];
            r_wrap   <= wbs_dat_i[1];
            r_invert <= wbs_dat_i[2];
        end
    end

    // Shared PWM counter, period 2^WIDTH-1, parked at 0 while disabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
            pwm_out   <= '0;
        end else begin
            if (!r_enable || (r_pwm_cnt == CNT_LAST)) r_pwm_cnt <= '0;
            else                                       r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
            pwm_out <= w_raw ^ {CHANNELS{r_invert}};
        end
    end

    // Read mux
    always_comb begin
        w_rdata = '0;
        if (w_idx == '0) w_rdata = {29'd0, r_invert, r_wrap, r_enable};
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_idx == IDX_W'(i + 1)) w_rdata = 32'(w_level[i]);
        end
    end

    // Single-cycle ack; a request is never accepted while ack is high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= w_req;
            if (w_req) wbs_dat_o <= w_rdata;
        end
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
module tb_enc_pwm_mixer;

    localparam int NCH = 3;
    localparam int MAXL = 255;

    logic            clk;
    logic            reset_n;
    logic [NCH-1:0]  enc_a;
    logic [NCH-1:0]  enc_b;
    logic [NCH-1:0]  pwm_out;
    logic            wbs_cyc_i;
    logic            wbs_stb_i;
    logic            wbs_we_i;
    logic [3:0]      wbs_sel_i;
    logic [31:0]     wbs_adr_i;
    logic [31:0]     wbs_dat_i;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_lvl [NCH];
    bit m_en;
    bit m_wrap;
    bit m_inv;

    enc_pwm_mixer #(.CHANNELS(NCH), .WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .pwm_out   (pwm_out),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int stepped(input int l, input bit down, input bit wrap);
        int v;
        v = down ? l - 1 : l + 1;
        if (wrap) return (v + MAXL + 1) % (MAXL + 1);
        if (v < 0) return 0;
        if (v > MAXL) return MAXL;
        return v;
    endfunction

    function automatic int merged(input int old, input int data, input logic [3:0] sel);
        int mask;
        mask = 0;
        for (int b = 0; b < 4; b++) if (sel[b]) mask |= (32'hFF << (8 * b));
        return ((old & ~mask) | (data & mask)) & MAXL;
    endfunction

    // One bus transaction; ack must appear exactly one cycle after the request
    task automatic wb_xfer(input bit we, input int idx, input logic [31:0] data,
                           input logic [3:0] sel, output logic [31:0] rd);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = 32'(idx) << 2; wbs_dat_i = data; wbs_sel_i = sel;
        @(negedge clk);
        check($sformatf("ack_idx%0d", idx), 32'(wbs_ack_o), 32'd1);
        rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        check("ack_single", 32'(wbs_ack_o), 32'd0);
    endtask

    task automatic wb_write(input int idx, input int data, input logic [3:0] sel);
        logic [31:0] rd;
        wb_xfer(1'b1, idx, 32'(data), sel, rd);
        if (idx == 0 && sel[0]) begin
            m_en = data[0]; m_wrap = data[1]; m_inv = data[2];
        end else if (idx >= 1 && idx <= NCH) begin
            m_lvl[idx-1] = merged(m_lvl[idx-1], data, sel);
        end
    endtask

    task automatic rd_check(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, idx, 32'd0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    task automatic rd_level(input int ch);
        rd_check($sformatf("level%0d", ch), ch + 1, 32'(m_lvl[ch]));
    endtask

    task automatic enc_pulse(input int ch, input bit down);
        @(negedge clk);
        enc_b[ch] = down;
        @(negedge clk);
        enc_a[ch] = 1'b1;
        repeat (4) @(negedge clk);
        enc_a[ch] = 1'b0;
        repeat (4) @(negedge clk);
        m_lvl[ch] = stepped(m_lvl[ch], down, m_wrap);
    endtask

    // Over any 255 consecutive cycles the high count equals the duty numerator
    task automatic duty_check(input string tag, input int ch);
        int highs;
        int exp;
        repeat (4) @(negedge clk);
        highs = 0;
        repeat (MAXL) begin
            @(negedge clk);
            highs += int'(pwm_out[ch]);
        end
        if (!m_en)      exp = m_inv ? MAXL : 0;
        else if (m_inv) exp = MAXL - m_lvl[ch];
        else            exp = m_lvl[ch];
        check(tag, 32'(highs), 32'(exp));
    endtask

    initial begin
        logic [31:0] rd;
        int ch;
        int op;
        reset_n = 1'b0;
        enc_a = '0; enc_b = '0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        for (int i = 0; i < NCH; i++) m_lvl[i] = 0;
        m_en = 1'b1; m_wrap = 1'b0; m_inv = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Register defaults
        rd_check("ctrl_rst", 0, 32'h1);
        for (int i = 0; i < NCH; i++) rd_level(i);
        check("pwm_idle", 32'(pwm_out), 32'd0);

        // Saturating count on channel 0
        repeat (5) enc_pulse(0, 1'b0);
        rd_check("lvl0_up5", 1, 32'd5);
        repeat (7) enc_pulse(0, 1'b1);
        rd_check("lvl0_sat0", 1, 32'd0);

        // Wrap mode at both ends
        wb_write(0, 32'h3, 4'hF);
        wb_write(2, 32'hFF, 4'hF);
        enc_pulse(1, 1'b0);
        rd_check("lvl1_wrap_up", 2, 32'h00);
        enc_pulse(1, 1'b1);
        rd_check("lvl1_wrap_dn", 2, 32'hFF);

        // Duty cycle
        wb_write(3, 64, 4'hF);
        duty_check("duty64", 2);
        wb_write(3, 255, 4'hF);
        duty_check("duty255", 2);
        wb_write(3, 0, 4'hF);
        duty_check("duty0", 2);

        // Disabled with invert: outputs forced high
        wb_write(0, 32'h4, 4'hF);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("dis_inv_pwm", 32'(pwm_out), 32'h7);
            repeat (17) @(negedge clk);
        end
        rd_check("ctrl_inv", 0, 32'h4);
        wb_write(3, 100, 4'hF);
        wb_write(0, 32'h5, 4'hF);
        duty_check("duty_inv100", 2);
        duty_check("duty_inv_ch1", 1);

        // Byte-lane gating, write/step collision, unmapped index
        wb_write(1, 32'h77, 4'h0);
        rd_check("lvl0_sel0", 1, 32'(m_lvl[0]));
        @(negedge clk);
        enc_b[0] = 1'b0;
        @(negedge clk);
        enc_a[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'd4; wbs_dat_i = 32'h20; wbs_sel_i = 4'h1;
        @(negedge clk);
        check("ack_collide", 32'(wbs_ack_o), 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        m_lvl[0] = 32'h20;
        repeat (3) @(negedge clk);
        enc_a[0] = 1'b0;
        repeat (4) @(negedge clk);
        rd_check("lvl0_collide", 1, 32'h20);
        wb_write(40, 32'hDEAD, 4'hF);
        rd_check("idx40", 40, 32'd0);
        for (int i = 0; i < NCH; i++) rd_level(i);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 5);
            ch = $urandom_range(0, NCH - 1);
            if (op <= 2) begin
                repeat ($urandom_range(1, 3)) enc_pulse(ch, 1'($urandom_range(0, 1)));
            end else if (op == 3) begin
                wb_write(ch + 1, $urandom, 4'($urandom));
            end else if (op == 4) begin
                if ($urandom_range(0, 1) == 1) wb_write(ch + 1, 255 - $urandom_range(0, 1), 4'hF);
                else                           wb_write(ch + 1, $urandom_range(0, 1), 4'hF);
            end else begin
                wb_write(0, 1 | ($urandom_range(0, 3) << 1), 4'h1);
            end
            rd_level(ch);
        end
        rd_check("ctrl_final", 0, {29'd0, m_inv, m_wrap, m_en});
        duty_check("duty_rand", $urandom_range(0, NCH - 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
